// File: rtl/v_dmem_port.sv
// Vector load/store responder: turns one vector memory request into
// one-word-per-cycle accesses on a single-port, synchronous-read data memory.
module v_dmem_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [3:0]        v_lsu_op,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       base_addr,
  input  logic [31:0]       stride,
  input  logic [2:0]        elem_cnt,
  input  logic [DATA_W-1:0] v_store_data_0,
  input  logic [DATA_W-1:0] v_store_data_1,
  input  logic [DATA_W-1:0] v_store_data_2,
  input  logic [DATA_W-1:0] v_store_data_3,
  output logic [DATA_W-1:0] v_load_data_0,
  output logic [DATA_W-1:0] v_load_data_1,
  output logic [DATA_W-1:0] v_load_data_2,
  output logic [DATA_W-1:0] v_load_data_3,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_wr_en,
  output logic [DATA_W-1:0] dmem_wr_data,
  input  logic [DATA_W-1:0] dmem_rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic              r_is_store;
  logic [31:0]       r_addr;
  logic [31:0]       r_stride;
  logic [2:0]        r_n;
  logic [2:0]        r_k;
  logic [DATA_W-1:0] r_st [4];
  logic              r_rd_pend;
  logic [1:0]        r_rd_slot;
  logic              r_cap;
  logic [1:0]        r_cap_slot;
  logic [DATA_W-1:0] r_ld [4];
  logic              r_done;
  logic              r_err;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_accept;
  logic              w_is_store;
  logic              w_is_strided;
  logic              w_err;
  logic [31:0]       w_stride_eff;
  logic [31:0]       w_next_addr;
  logic [1:0]        w_k_next;

  assign w_accept     = req_valid && (r_state == S_IDLE);
  assign w_is_store   = (v_lsu_op == 4'h2) || (v_lsu_op == 4'h4);
  assign w_is_strided = (v_lsu_op == 4'h3) || (v_lsu_op == 4'h4);
  assign w_err        = (v_lsu_op == 4'h0) || (v_lsu_op > 4'h4) || (elem_cnt > 3'd4) ||
                        (base_addr[1:0] != 2'b00) || (w_is_strided && (stride[1:0] != 2'b00));
  assign w_stride_eff = w_is_strided ? stride : 32'd4;
  // Running address replaces the k*stride product with one add per beat.
  assign w_next_addr  = r_addr + r_stride;
  assign w_k_next     = r_k[1:0] + 2'd1;

  // NOTE: the store buffer is pure datapath, only read after a fresh accept, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_st[0] <= v_store_data_0;
      r_st[1] <= v_store_data_1;
      r_st[2] <= v_store_data_2;
      r_st[3] <= v_store_data_3;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state     <= S_IDLE;
      r_is_store  <= 1'b0;
      r_addr      <= '0;
      r_stride    <= '0;
      r_n         <= '0;
      r_k         <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_slot   <= '0;
      r_cap       <= 1'b0;
      r_cap_slot  <= '0;
      r_ld        <= '{default: '0};
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_wr_en     <= 1'b0;
      r_dmem_addr <= '0;
      r_wr_data   <= '0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      // Read data appears one cycle after its address; a two-stage tag tracks the slot.
      r_rd_pend  <= 1'b0;
      r_cap      <= r_rd_pend;
      r_cap_slot <= r_rd_slot;
      if (r_cap) r_ld[r_cap_slot] <= dmem_rd_data;

      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_store <= w_is_store;
            r_stride   <= w_stride_eff;
            r_n        <= elem_cnt;
            r_k        <= '0;
            r_addr     <= base_addr;
            if (w_err) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              if (!w_is_store) r_ld <= '{default: '0};
              if (elem_cnt == 3'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state     <= S_RUN;
                r_wr_en     <= w_is_store;
                r_dmem_addr <= base_addr[ADDR_W+1:2];
                if (w_is_store) begin
                  r_wr_data <= v_store_data_0;
                end else begin
                  r_rd_pend <= 1'b1;
                  r_rd_slot <= 2'd0;
                end
              end
            end
          end
        end
        S_RUN: begin
          if (r_k == r_n - 3'd1) begin
            r_wr_en <= 1'b0;
            if (r_is_store) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_k         <= r_k + 3'd1;
            r_addr      <= w_next_addr;
            r_dmem_addr <= w_next_addr[ADDR_W+1:2];
            if (r_is_store) begin
              r_wr_data <= r_st[w_k_next];
            end else begin
              r_rd_pend <= 1'b1;
              r_rd_slot <= w_k_next;
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign err           = r_err;
  assign dmem_addr     = r_dmem_addr;
  assign dmem_wr_en    = r_wr_en;
  assign dmem_wr_data  = r_wr_data;
  assign v_load_data_0 = r_ld[0];
  assign v_load_data_1 = r_ld[1];
  assign v_load_data_2 = r_ld[2];
  assign v_load_data_3 = r_ld[3];

endmodule

// File: tb/tb_v_dmem_port.sv
// Bench for v_dmem_port: directed vector table, reset-abort sequence and
// random requests checked against an address/memory model of the request rules.
module tb_v_dmem_port;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [3:0]  v_lsu_op = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] base_addr = '0;
  logic [31:0] stride = '0;
  logic [2:0]  elem_cnt = '0;
  logic [31:0] v_store_data_0 = '0, v_store_data_1 = '0, v_store_data_2 = '0, v_store_data_3 = '0;
  logic [31:0] v_load_data_0, v_load_data_1, v_load_data_2, v_load_data_3;
  logic        done, err, busy;
  logic [11:0] dmem_addr;
  logic        dmem_wr_en;
  logic [31:0] dmem_wr_data;
  logic [31:0] dmem_rd_data = '0;

  v_dmem_port #(.DATA_W(32), .ADDR_W(12)) dut (
    .clk(clk), .nrst(nrst), .v_lsu_op(v_lsu_op), .req_valid(req_valid), .req_ready(req_ready),
    .base_addr(base_addr), .stride(stride), .elem_cnt(elem_cnt),
    .v_store_data_0(v_store_data_0), .v_store_data_1(v_store_data_1),
    .v_store_data_2(v_store_data_2), .v_store_data_3(v_store_data_3),
    .v_load_data_0(v_load_data_0), .v_load_data_1(v_load_data_1),
    .v_load_data_2(v_load_data_2), .v_load_data_3(v_load_data_3),
    .done(done), .err(err), .busy(busy),
    .dmem_addr(dmem_addr), .dmem_wr_en(dmem_wr_en), .dmem_wr_data(dmem_wr_data),
    .dmem_rd_data(dmem_rd_data)
  );

  always #5 clk = ~clk;

  // Unwritten words read back as a fixed function of their address (preloaded memory).
  function automatic logic [31:0] init_val(input logic [11:0] a);
    return ({20'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  logic [31:0] t_mem [4096];
  bit          t_wr  [4096];
  always @(posedge clk) begin
    if (dmem_wr_en) begin
      t_mem[dmem_addr] <= dmem_wr_data;
      t_wr[dmem_addr]  <= 1'b1;
    end
    dmem_rd_data <= t_wr[dmem_addr] ? t_mem[dmem_addr] : init_val(dmem_addr);
  end

  // Reference model state
  logic [31:0] m_mem [4096];
  bit          m_wr  [4096];
  logic [31:0] exp_ld [4];
  logic [11:0] last_addr;
  logic [31:0] last_wdata;

  function automatic logic [31:0] m_rd(input logic [11:0] a);
    return m_wr[a] ? m_mem[a] : init_val(a);
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_rules(input logic [3:0] op, input logic [31:0] base,
                                      input logic [31:0] str, input logic [2:0] n,
                                      output logic e, output int lat);
    logic st, sd;
    st  = (op == 4'h2) || (op == 4'h4);
    sd  = (op == 4'h3) || (op == 4'h4);
    e   = !(op >= 4'h1 && op <= 4'h4) || (n > 3'd4) || (base[1:0] != 2'b00) ||
          (sd && str[1:0] != 2'b00);
    lat = (e || n == 3'd0) ? 1 : (st ? int'(n) + 1 : int'(n) + 2);
  endfunction

  task automatic check_loads(input string tag);
    check({tag, "_ld0"}, v_load_data_0, exp_ld[0]);
    check({tag, "_ld1"}, v_load_data_1, exp_ld[1]);
    check({tag, "_ld2"}, v_load_data_2, exp_ld[2]);
    check({tag, "_ld3"}, v_load_data_3, exp_ld[3]);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] base,
                        input logic [31:0] str, input logic [2:0] n,
                        input logic [3:0][31:0] st, input logic exp_err, input int exp_lat);
    logic        is_st, is_sd, beat;
    logic [31:0] eff, a;
    int          guard;
    int          k;
    is_st = (op == 4'h2) || (op == 4'h4);
    is_sd = (op == 4'h3) || (op == 4'h4);
    eff   = is_sd ? str : 32'd4;
    @(negedge clk);
    v_lsu_op = op; base_addr = base; stride = str; elem_cnt = n;
    v_store_data_0 = st[0]; v_store_data_1 = st[1]; v_store_data_2 = st[2]; v_store_data_3 = st[3];
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    v_lsu_op = 4'($urandom); base_addr = $urandom; stride = $urandom; elem_cnt = 3'($urandom);
    v_store_data_0 = $urandom; v_store_data_1 = $urandom;
    v_store_data_2 = $urandom; v_store_data_3 = $urandom;
    if (!exp_err && !is_st) exp_ld = '{default: '0};
    for (int i = 1; i <= exp_lat; i++) begin
      @(negedge clk);
      k    = i - 1;
      beat = !exp_err && (k < int'(n));
      a    = base + 32'(k) * eff;
      check({tag, "_wr_en"}, dmem_wr_en, beat && is_st);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_done"}, done, i == exp_lat);
      if (beat) begin
        check({tag, "_addr"}, dmem_addr, a[13:2]);
        last_addr = a[13:2];
        if (is_st) begin
          check({tag, "_wdata"}, dmem_wr_data, st[k]);
          last_wdata = st[k];
          m_mem[a[13:2]] = st[k];
          m_wr[a[13:2]]  = 1'b1;
        end else begin
          exp_ld[k] = m_rd(a[13:2]);
        end
      end else begin
        check({tag, "_addr_hold"}, dmem_addr, last_addr);
      end
      if (!(beat && is_st)) check({tag, "_wdata_hold"}, dmem_wr_data, last_wdata);
      if (i == exp_lat) begin
        check({tag, "_err"}, err, exp_err);
        check_loads(tag);
      end
    end
    @(negedge clk);
    check({tag, "_idle_after"}, req_ready, 1'b1);
    check({tag, "_done_clear"}, done, 1'b0);
  endtask

  typedef struct {
    string            name;
    logic [3:0]       op;
    logic [31:0]      base;
    logic [31:0]      str;
    logic [2:0]       n;
    logic [3:0][31:0] st;
    logic             exp_err;
    int               exp_lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]       op;
    logic [31:0]      base, str;
    logic [2:0]       n;
    logic [3:0][31:0] st;
    logic             e;
    int               lat;

    vecs[0] = '{"vse_a",    4'h2, 32'h100,       32'h0,  3'd4, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, 5};
    vecs[1] = '{"vle_a",    4'h1, 32'h100,       32'h7,  3'd4, '0,                               1'b0, 6};
    vecs[2] = '{"vlse",     4'h3, 32'h200,       32'h10, 3'd3, '0,                               1'b0, 5};
    vecs[3] = '{"e_base",   4'h1, 32'h102,       32'h0,  3'd2, '0,                               1'b1, 1};
    vecs[4] = '{"e_op7",    4'h7, 32'h100,       32'h4,  3'd2, '0,                               1'b1, 1};
    vecs[5] = '{"e_cnt5",   4'h2, 32'h100,       32'h0,  3'd5, {4{32'hDEAD_BEEF}},               1'b1, 1};
    vecs[6] = '{"e_str6",   4'h4, 32'h100,       32'h6,  3'd2, {4{32'hDEAD_BEEF}},               1'b1, 1};
    vecs[7] = '{"vsse_wr",  4'h4, 32'hFFFF_FFF8, 32'h8,  3'd2, {32'h0, 32'h0, 32'hC1, 32'hC0},   1'b0, 3};
    vecs[8] = '{"vle_n0",   4'h1, 32'h100,       32'h0,  3'd0, '0,                               1'b0, 1};
    vecs[9] = '{"vlse_wr",  4'h3, 32'hFFFF_FFF8, 32'h8,  3'd2, '0,                               1'b0, 4};

    exp_ld     = '{default: '0};
    last_addr  = '0;
    last_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_wr_en", dmem_wr_en, 1'b0);
    check("rst_addr", dmem_addr, 12'h0);
    check("rst_wdata", dmem_wr_data, 32'h0);
    check_loads("rst");
    nrst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].base, vecs[i].str, vecs[i].n,
             vecs[i].st, vecs[i].exp_err, vecs[i].exp_lat);

    // Reset during a 4-beat store: only beat 0 lands in memory, no done.
    @(negedge clk);
    v_lsu_op = 4'h2; base_addr = 32'h300; stride = 32'h0; elem_cnt = 3'd4;
    v_store_data_0 = 32'hB0; v_store_data_1 = 32'hB1; v_store_data_2 = 32'hB2; v_store_data_3 = 32'hB3;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_beat0_wr", dmem_wr_en, 1'b1);
    check("abort_beat0_addr", dmem_addr, 12'h0C0);
    m_mem[12'h0C0] = 32'hB0;
    m_wr[12'h0C0]  = 1'b1;
    nrst = 1'b1;
    @(negedge clk);
    check("abort_wr_en", dmem_wr_en, 1'b0);
    check("abort_ready", req_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    nrst = 1'b0;
    last_addr  = '0;
    last_wdata = '0;
    exp_ld     = '{default: '0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_quiet_done", done, 1'b0);
      check("abort_quiet_wr", dmem_wr_en, 1'b0);
    end
    run_op("abort_readback", 4'h1, 32'h300, 32'h0, 3'd4, '0, 1'b0, 6);

    // Random requests against the rule model
    for (int t = 0; t < 40; t++) begin
      op   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(1, 4));
      base = $urandom & ~32'h3;
      if ($urandom_range(0, 9) == 0) base[1:0] = 2'($urandom_range(1, 3));
      str  = 32'($urandom_range(0, 16)) * 32'd4 - 32'd32;
      if ($urandom_range(0, 9) == 0) str[1:0] = 2'd2;
      n    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      st   = {$urandom, $urandom, $urandom, $urandom};
      model_rules(op, base, str, n, e, lat);
      run_op("rand", op, base, str, n, st, e, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
